// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM state encoding and the generator/capture
// default sizing, so generator and capture agree on the nominal period.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_SEEK = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int CNT_W_DEF   = 18;
    localparam int TIMEOUT_DEF = 200000;
    localparam int PWM_PERIOD  = 2001;

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a FILT_LEN-sample glitch filter.
// Emits the filtered level plus one-cycle rise/fall strobes aligned with it.
module sync_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
        $error("sync_filter: FILT_LEN must be in 1..15");
    end

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;
    logic       w_flip;

    // FILT_LEN-th consecutive disagreeing sample flips the level this cycle
    assign w_flip = (r_sync[1] != r_level) && (r_cnt == 4'(FILT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            if (r_sync[1] == r_level || w_flip)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 4'd1;
            if (w_flip)
                r_level <= ~r_level;
            r_rise <= w_flip && !r_level;
            r_fall <= w_flip && r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures filtered high time and rise-to-rise period in clk
// cycles, and flags a stall when no rising edge arrives within TIMEOUT.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             stalled,
    output logic             stall_level
);

    if (longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    logic w_level, w_rise, w_fall;

    sync_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk     (clk),
        .rst     (rst),
        .i_din   (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hi_cnt, w_hi_nxt;
    logic [CNT_W-1:0] r_per_cnt, w_per_nxt, w_per_inc;
    logic [CNT_W-1:0] r_high_time, w_high_time_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_stalled, w_stalled_nxt;
    logic             r_stall_level, w_stall_level_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_SEEK;
            r_hi_cnt      <= '0;
            r_per_cnt     <= '0;
            r_high_time   <= '0;
            r_period      <= '0;
            r_valid       <= 1'b0;
            r_stalled     <= 1'b0;
            r_stall_level <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hi_cnt      <= w_hi_nxt;
            r_per_cnt     <= w_per_nxt;
            r_high_time   <= w_high_time_nxt;
            r_period      <= w_period_nxt;
            r_valid       <= w_valid_nxt;
            r_stalled     <= w_stalled_nxt;
            r_stall_level <= w_stall_level_nxt;
        end
    end

    assign w_per_inc = (r_per_cnt == LP_TO) ? r_per_cnt : r_per_cnt + LP_ONE;

    always_comb begin
        w_state_nxt     = r_state;
        w_hi_nxt        = r_hi_cnt;
        w_per_nxt       = w_per_inc;
        w_high_time_nxt = r_high_time;
        w_period_nxt    = r_period;
        w_valid_nxt     = 1'b0;
        w_stalled_nxt   = r_stalled;

        case (r_state)
            ST_SEEK: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_hi_nxt    = LP_ONE;
                    w_per_nxt   = LP_ONE;
                end
            end
            ST_HIGH: begin
                // the falling-edge cycle already belongs to the low phase
                if (w_fall)
                    w_state_nxt = ST_LOW;
                else
                    w_hi_nxt = r_hi_cnt + LP_ONE;
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_high_time_nxt = r_hi_cnt;
                    w_period_nxt    = r_per_cnt;
                    w_valid_nxt     = 1'b1;
                    w_stalled_nxt   = 1'b0;
                    w_state_nxt     = ST_HIGH;
                    w_hi_nxt        = LP_ONE;
                    w_per_nxt       = LP_ONE;
                end
            end
            default: w_state_nxt = ST_SEEK;
        endcase

        // a rise landing exactly on the limit still completes the measurement
        if (r_per_cnt == LP_TO && !w_rise) begin
            w_state_nxt   = ST_SEEK;
            w_stalled_nxt = 1'b1;
            w_per_nxt     = LP_TO;
        end

        w_stall_level_nxt = w_stalled_nxt ? w_level : 1'b0;
    end

    assign high_time   = r_high_time;
    assign period      = r_period;
    assign meas_valid  = r_valid;
    assign stalled     = r_stalled;
    assign stall_level = r_stall_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: unit A (TIMEOUT 5000) for waveform tests,
// unit B (TIMEOUT 100) for the rise-on-limit boundary.
module tb_pwm_capture;

    localparam int W    = 18;
    localparam int TO_A = 5000;
    localparam int TO_B = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pwm_a = 1'b0;
    logic pwm_b = 1'b0;

    logic [W-1:0] a_high, a_per, b_high, b_per;
    logic a_valid, a_stalled, a_slevel;
    logic b_valid, b_stalled, b_slevel;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(W), .FILT_LEN(4), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst(rst), .pwm_in(pwm_a),
        .high_time(a_high), .period(a_per), .meas_valid(a_valid),
        .stalled(a_stalled), .stall_level(a_slevel)
    );

    pwm_capture #(.CNT_W(W), .FILT_LEN(4), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst(rst), .pwm_in(pwm_b),
        .high_time(b_high), .period(b_per), .meas_valid(b_valid),
        .stalled(b_stalled), .stall_level(b_slevel)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // observation of unit A
    int na = 0;
    int a_last_ht = 0, a_last_per = 0;
    logic a_vstall = 1'b0;
    int cyc_valid = -1, cyc_stall = -1;
    logic a_prev_stall = 1'b0;

    // observation of unit B
    int nb = 0;
    int b_last_ht = 0, b_last_per = 0;
    logic b_saw_stall = 1'b0;

    task automatic step(input logic a, input logic b);
        pwm_a = a;
        pwm_b = b;
        @(posedge clk);
        #1;
        cyc++;
        if (a_valid) begin
            na++;
            a_last_ht  = int'(a_high);
            a_last_per = int'(a_per);
            a_vstall   = a_stalled;
            cyc_valid  = cyc;
        end
        if (a_stalled && !a_prev_stall && cyc_stall < 0) cyc_stall = cyc;
        a_prev_stall = a_stalled;
        if (b_valid) begin
            nb++;
            b_last_ht  = int'(b_high);
            b_last_per = int'(b_per);
        end
        if (b_stalled) b_saw_stall = 1'b1;
    endtask

    task automatic run_a(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
    endtask

    task automatic per_a(input int hi, input int lo);
        run_a(1'b1, hi);
        run_a(1'b0, lo);
    endtask

    task automatic run_b(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(1'b0, lvl);
    endtask

    task automatic per_b(input int hi, input int lo);
        run_b(1'b1, hi);
        run_b(1'b0, lo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        na = 0; nb = 0;
        cyc_valid = -1; cyc_stall = -1;
        a_prev_stall = 1'b0; b_saw_stall = 1'b0;
        run_a(1'b0, 10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++; if (a_high !== '0) begin errors++; $display("FAIL reset_high_time got %0d want 0", a_high); end
        checks++; if (a_per !== '0) begin errors++; $display("FAIL reset_period got %0d want 0", a_per); end
        checks++; if ({a_valid, a_stalled, a_slevel} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {a_valid, a_stalled, a_slevel}); end
        checks++; if ({b_valid, b_stalled, b_slevel} !== 3'b000) begin errors++; $display("FAIL reset_flags_b got %b want 000", {b_valid, b_stalled, b_slevel}); end
        rst = 1'b0;
    endtask

    task automatic test_gen_pwm();
        do_reset();
        per_a(1000, 1001);
        checks++; if (na !== 0) begin errors++; $display("FAIL gen_first_period_valids got %0d want 0", na); end
        for (int p = 1; p <= 2; p++) begin
            per_a(1000, 1001);
            checks++; if (na !== p) begin errors++; $display("FAIL gen_valid_count got %0d want %0d", na, p); end
            checks++; if (a_last_ht !== 1000 || a_last_per !== 2001) begin errors++; $display("FAIL gen_values got %0d/%0d want 1000/2001", a_last_ht, a_last_per); end
        end
        run_a(1'b1, 10);
        checks++; if (na !== 3) begin errors++; $display("FAIL gen_third_valid got %0d want 3", na); end
        checks++; if (a_last_ht !== 1000 || a_last_per !== 2001) begin errors++; $display("FAIL gen_third_values got %0d/%0d want 1000/2001", a_last_ht, a_last_per); end
    endtask

    task automatic test_duty_sweep();
        do_reset();
        per_a(50, 1951);
        per_a(1950, 51);
        checks++; if (na !== 1) begin errors++; $display("FAIL sweep_count_min got %0d want 1", na); end
        checks++; if (a_last_ht !== 50 || a_last_per !== 2001) begin errors++; $display("FAIL sweep_min got %0d/%0d want 50/2001", a_last_ht, a_last_per); end
        per_a(1950, 51);
        checks++; if (na !== 2) begin errors++; $display("FAIL sweep_count_max got %0d want 2", na); end
        checks++; if (a_last_ht !== 1950 || a_last_per !== 2001) begin errors++; $display("FAIL sweep_max got %0d/%0d want 1950/2001", a_last_ht, a_last_per); end
        run_a(1'b1, 10);
        checks++; if (na !== 3 || a_last_ht !== 1950) begin errors++; $display("FAIL sweep_max2 got n=%0d ht=%0d want n=3 ht=1950", na, a_last_ht); end
    endtask

    task automatic test_glitch();
        do_reset();
        per_a(500, 1501);
        run_a(1'b1, 500);
        run_a(1'b0, 700);
        run_a(1'b1, 3);
        run_a(1'b0, 798);
        run_a(1'b1, 10);
        checks++; if (na !== 2) begin errors++; $display("FAIL glitch3_count got %0d want 2", na); end
        checks++; if (a_last_ht !== 500 || a_last_per !== 2001) begin errors++; $display("FAIL glitch3_values got %0d/%0d want 500/2001", a_last_ht, a_last_per); end
        run_a(1'b1, 490);
        run_a(1'b0, 700);
        run_a(1'b1, 4);
        run_a(1'b0, 797);
        checks++; if (na !== 3) begin errors++; $display("FAIL glitch4_count got %0d want 3", na); end
        checks++; if (a_last_ht !== 500 || a_last_per !== 1200) begin errors++; $display("FAIL glitch4_short got %0d/%0d want 500/1200", a_last_ht, a_last_per); end
        run_a(1'b1, 10);
        checks++; if (na !== 4 || a_last_ht !== 4 || a_last_per !== 801) begin errors++; $display("FAIL glitch4_pulse got n=%0d %0d/%0d want n=4 4/801", na, a_last_ht, a_last_per); end
    endtask

    task automatic test_stall();
        do_reset();
        per_a(1000, 1001);
        run_a(1'b1, 5100);
        checks++; if (na !== 1) begin errors++; $display("FAIL stall_pre_count got %0d want 1", na); end
        checks++; if (cyc_stall - cyc_valid !== TO_A) begin errors++; $display("FAIL stall_delay got %0d want %0d", cyc_stall - cyc_valid, TO_A); end
        checks++; if (a_stalled !== 1'b1 || a_slevel !== 1'b1) begin errors++; $display("FAIL stall_high got %b%b want 11", a_stalled, a_slevel); end
        checks++; if (a_high !== 18'd1000 || a_per !== 18'd2001) begin errors++; $display("FAIL stall_hold got %0d/%0d want 1000/2001", a_high, a_per); end
        run_a(1'b0, 1001);
        checks++; if (a_stalled !== 1'b1 || a_slevel !== 1'b0) begin errors++; $display("FAIL stall_low got %b%b want 10", a_stalled, a_slevel); end
        run_a(1'b1, 1000);
        checks++; if (na !== 1 || a_stalled !== 1'b1) begin errors++; $display("FAIL stall_first_rise got n=%0d st=%b want n=1 st=1", na, a_stalled); end
        run_a(1'b0, 1001);
        run_a(1'b1, 10);
        checks++; if (na !== 2 || a_vstall !== 1'b0) begin errors++; $display("FAIL stall_clear got n=%0d st_at_valid=%b want n=2 st=0", na, a_vstall); end
        checks++; if (a_last_ht !== 1000 || a_last_per !== 2001) begin errors++; $display("FAIL stall_resume got %0d/%0d want 1000/2001", a_last_ht, a_last_per); end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        for (int p = 0; p < 3; p++) per_b(30, 70);
        run_b(1'b1, 10);
        checks++; if (nb !== 3) begin errors++; $display("FAIL to_edge_count got %0d want 3", nb); end
        checks++; if (b_last_per !== TO_B || b_last_ht !== 30) begin errors++; $display("FAIL to_edge_values got %0d/%0d want 30/%0d", b_last_ht, b_last_per, TO_B); end
        checks++; if (b_saw_stall !== 1'b0) begin errors++; $display("FAIL to_edge_stall got %b want 0", b_saw_stall); end
        run_b(1'b1, 20);
        run_b(1'b0, 71);
        run_b(1'b1, 10);
        checks++; if (nb !== 3 || b_stalled !== 1'b1) begin errors++; $display("FAIL to_over_limit got n=%0d st=%b want n=3 st=1", nb, b_stalled); end
    endtask

    task automatic test_reset_mid_high();
        do_reset();
        per_a(1000, 1001);
        run_a(1'b1, 500);
        checks++; if (na !== 1) begin errors++; $display("FAIL rmid_pre got %0d want 1", na); end
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        na = 0;
        checks++; if (a_high !== '0 || a_per !== '0 || {a_valid, a_stalled, a_slevel} !== 3'b000) begin errors++; $display("FAIL rmid_clear got %0d/%0d %b want 0/0 000", a_high, a_per, {a_valid, a_stalled, a_slevel}); end
        run_a(1'b1, 499);
        run_a(1'b0, 1001);
        checks++; if (na !== 0) begin errors++; $display("FAIL rmid_no_partial got %0d want 0", na); end
        run_a(1'b1, 10);
        checks++; if (na !== 1 || a_last_ht !== 499 || a_last_per !== 1500) begin errors++; $display("FAIL rmid_first got n=%0d %0d/%0d want n=1 499/1500", na, a_last_ht, a_last_per); end
        run_a(1'b1, 990);
        run_a(1'b0, 1001);
        run_a(1'b1, 10);
        checks++; if (na !== 2 || a_last_ht !== 1000 || a_last_per !== 2001) begin errors++; $display("FAIL rmid_second got n=%0d %0d/%0d want n=2 1000/2001", na, a_last_ht, a_last_per); end
    endtask

    initial begin
        test_reset();
        test_gen_pwm();
        test_duty_sweep();
        test_glitch();
        test_stall();
        test_timeout_edge();
        test_reset_mid_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
